// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_structures (package)
// Brief    : Shared RISC-V fetch constants and the fetch packet type.
// Revision : 1.0
// ============================================================================
package riscv_structures;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two prefetch FIFO of fetch packets with synchronous flush.
// Revision : 1.0
// ============================================================================
module fetch_fifo
  import riscv_structures::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fetch_pkt_t               i_data,
  input  logic                     i_pop,
  output fetch_pkt_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ptr_one = 1;
  localparam logic [AW:0]   c_cnt_one = 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  fetch_pkt_t    r_mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Sequential PC fetch with redirect, feeding a prefetch buffer.
// Revision : 1.0
// ============================================================================
module instr_fetch
  import riscv_structures::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] fetch_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   c_depth       = CW'(DEPTH);
  localparam logic [XLEN-1:0] c_instr_bytes = XLEN'(INSTR_BYTES);
  localparam logic [31:0]     c_cnt_one     = 32'd1;

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_fetch_cnt;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_pop;
  fetch_pkt_t      w_head;
  fetch_pkt_t      w_pkt;
  logic            w_unused_bits;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_push = !redirect_valid &&
                  ((w_count < c_depth) || ((w_count == c_depth) && out_ready));
  assign w_pop  = out_valid && out_ready;

  assign w_pkt.pc    = r_pc;
  assign w_pkt.instr = imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc        <= {redirect_pc[31:2], 2'b00};
    end else if (w_push) begin
      r_pc        <= r_pc + c_instr_bytes;
      r_fetch_cnt <= r_fetch_cnt + c_cnt_one;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_pkt),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_addr = r_pc;
  assign fetch_cnt = r_fetch_cnt;
  assign out_valid = (w_count != '0);
  // Masked so an empty buffer never exposes unreset storage.
  assign out_pc    = out_valid ? w_head.pc    : '0;
  assign out_instr = out_valid ? w_head.instr : '0;

  assign w_unused_bits = ^redirect_pc[1:0];

endmodule
`default_nettype wire
